// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around a combinational ALU: register file,
// EX operand register with forwarding, and flag/retire bookkeeping.
module alu_issue_wb #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [3:0]        in_aluc,
   input  logic              hold,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_waddr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_aluc,
   input  logic [DATA_W-1:0] alu_r,
   input  logic              alu_zero,
   input  logic              alu_carry,
   input  logic              alu_negative,
   input  logic              alu_overflow,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_rd,
   output logic [3:0]        flags_q,
   output logic [31:0]       retire_cnt,
   input  logic [ADDR_W-1:0] dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   logic [DATA_W-1:0] rf_q [NREG];
   logic              ex_valid_q;
   logic [ADDR_W-1:0] ex_rd_q;
   logic [DATA_W-1:0] a_q, b_q, a_d, b_d;
   logic [3:0]        aluc_q;
   logic              wb_valid_q;
   logic [ADDR_W-1:0] wb_rd_q;
   logic [31:0]       cnt_q, cnt_d;
   logic              accept, wb_fire;

   assign in_ready = ~hold;
   assign accept   = in_valid & ~hold;
   assign wb_fire  = ex_valid_q & ~hold;
   assign cnt_d    = cnt_q + 32'd1;

   // In-flight EX result beats a same-edge loader write, which beats the rf.
   always_comb begin
      a_d = rf_q[in_rs];
      if (in_rs == '0)
         a_d = '0;
      else if (ex_valid_q && ex_rd_q == in_rs)
         a_d = alu_r;
      else if (ext_we && ext_waddr == in_rs)
         a_d = ext_wdata;
   end

   always_comb begin
      b_d = rf_q[in_rt];
      if (in_rt == '0)
         b_d = '0;
      else if (ex_valid_q && ex_rd_q == in_rt)
         b_d = alu_r;
      else if (ext_we && ext_waddr == in_rt)
         b_d = ext_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_rd_q    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         aluc_q     <= '0;
      end else if (!hold) begin
         ex_valid_q <= accept;
         if (accept) begin
            ex_rd_q <= in_rd;
            a_q     <= a_d;
            b_q     <= b_d;
            aluc_q  <= in_aluc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         flags_q    <= '0;
         cnt_q      <= '0;
      end else begin
         wb_valid_q <= wb_fire;
         if (wb_fire) begin
            wb_rd_q <= ex_rd_q;
            flags_q <= {alu_zero, alu_carry, alu_negative, alu_overflow};
            cnt_q   <= cnt_d;
         end
      end
   end

   // Writeback is assigned last so it wins a same-address loader write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= '0;
      end else begin
         if (ext_we && ext_waddr != '0)
            rf_q[ext_waddr] <= ext_wdata;
         if (wb_fire && ex_rd_q != '0)
            rf_q[ex_rd_q] <= alu_r;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_aluc   = aluc_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign retire_cnt = cnt_q;
   assign dbg_rdata  = (dbg_raddr == '0) ? '0 : rf_q[dbg_raddr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb; an adder stands in for the ALU.
module tb_alu_issue_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [3:0]  in_aluc;
   logic        hold, ext_we;
   logic [4:0]  ext_waddr;
   logic [31:0] ext_wdata;
   logic [31:0] alu_a, alu_b, alu_r;
   logic [3:0]  alu_aluc;
   logic        alu_zero, alu_carry, alu_negative, alu_overflow;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [3:0]  flags_q;
   logic [31:0] retire_cnt;
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;

   always #5 clk = ~clk;

   assign {alu_carry, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_zero     = (alu_r == 32'd0);
   assign alu_negative = alu_r[31];
   assign alu_overflow = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);

   alu_issue_wb dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_aluc(in_aluc),
      .hold(hold), .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
      .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
      .alu_zero(alu_zero), .alu_carry(alu_carry),
      .alu_negative(alu_negative), .alu_overflow(alu_overflow),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flags_q(flags_q),
      .retire_cnt(retire_cnt), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   typedef struct {
      logic [4:0]  rs, rt, rd;
      logic [3:0]  aluc;
      logic [31:0] ea, eb, er;
      logic [3:0]  ef;
   } vec_t;

   vec_t vt [6];
   int n_pass = 0;
   int n_tot  = 0;
   logic [31:0] exp_ret = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_rf(input logic [4:0] a, input logic [31:0] exp, input string name);
      dbg_raddr = a;
      #1;
      chk(name, dbg_rdata, exp);
   endtask

   task automatic ext_load(input logic [4:0] a, input logic [31:0] d);
      ext_we = 1; ext_waddr = a; ext_wdata = d;
      tick();
      ext_we = 0;
   endtask

   task automatic set_op(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [3:0] c);
      in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd; in_aluc = c;
   endtask

   initial begin
      vt[0] = '{5'd1, 5'd2, 5'd3,  4'b1110, 32'h10,       32'h80000000, 32'h80000010, 4'b0010};
      vt[1] = '{5'd5, 5'd6, 5'd8,  4'h0,    32'hFFFFFFFF, 32'h1,        32'h0,        4'b1100};
      vt[2] = '{5'd7, 5'd6, 5'd9,  4'h3,    32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0011};
      vt[3] = '{5'd2, 5'd2, 5'd10, 4'h5,    32'h80000000, 32'h80000000, 32'h0,        4'b1101};
      vt[4] = '{5'd0, 5'd1, 5'd11, 4'h7,    32'h0,        32'h10,       32'h10,       4'b0000};
      vt[5] = '{5'd3, 5'd0, 5'd0,  4'h9,    32'h80000010, 32'h0,        32'h0,        4'b0010};

      rst_n = 0; in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_aluc = 0;
      hold = 0; ext_we = 0; ext_waddr = 0; ext_wdata = 0; dbg_raddr = 0;
      #1;
      chk("rst_alu_a", alu_a, 0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 0);
      chk("rst_flags", {28'd0, flags_q}, 0);
      chk("rst_retire", retire_cnt, 0);
      chk("rst_ready", {31'd0, in_ready}, 1);
      hold = 1; #1;
      chk("rst_ready_hold", {31'd0, in_ready}, 0);
      hold = 0;
      set_op(5'd0, 5'd0, 5'd1, 4'hF);
      tick();
      chk("rst_no_accept", {28'd0, alu_aluc}, 0);
      in_valid = 0;
      rst_n = 1;
      tick();

      ext_load(5'd1, 32'h10);
      ext_load(5'd2, 32'h80000000);
      ext_load(5'd5, 32'hFFFFFFFF);
      ext_load(5'd6, 32'h1);
      ext_load(5'd7, 32'h7FFFFFFF);

      for (int i = 0; i < 6; i++) begin
         set_op(vt[i].rs, vt[i].rt, vt[i].rd, vt[i].aluc);
         tick();
         in_valid = 0;
         chk($sformatf("v%0d_a", i), alu_a, vt[i].ea);
         chk($sformatf("v%0d_b", i), alu_b, vt[i].eb);
         chk($sformatf("v%0d_aluc", i), {28'd0, alu_aluc}, {28'd0, vt[i].aluc});
         tick();
         exp_ret++;
         chk($sformatf("v%0d_wbv", i), {31'd0, wb_valid}, 1);
         chk($sformatf("v%0d_wbrd", i), {27'd0, wb_rd}, {27'd0, vt[i].rd});
         chk($sformatf("v%0d_flags", i), {28'd0, flags_q}, {28'd0, vt[i].ef});
         chk($sformatf("v%0d_retire", i), retire_cnt, exp_ret);
         rd_rf(vt[i].rd, vt[i].er, $sformatf("v%0d_rf", i));
      end
      tick();
      chk("idle_wbv", {31'd0, wb_valid}, 0);

      // back-to-back dependent ops
      set_op(5'd1, 5'd6, 5'd3, 4'h1);
      tick();
      set_op(5'd3, 5'd3, 5'd12, 4'h2);
      tick();
      in_valid = 0;
      exp_ret++;
      chk("fwd_a", alu_a, 32'h11);
      chk("fwd_b", alu_b, 32'h11);
      chk("fwd_wbrd", {27'd0, wb_rd}, 3);
      rd_rf(5'd3, 32'h11, "fwd_rf3");
      tick();
      exp_ret++;
      chk("fwd_wbrd2", {27'd0, wb_rd}, 12);
      rd_rf(5'd12, 32'h22, "fwd_rf12");

      // hold with op in EX
      set_op(5'd6, 5'd6, 5'd13, 4'h4);
      tick();
      hold = 1;
      set_op(5'd1, 5'd1, 5'd14, 4'h4);
      #1;
      chk("hold_ready", {31'd0, in_ready}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("hold%0d_wbv", i), {31'd0, wb_valid}, 0);
         chk($sformatf("hold%0d_a", i), alu_a, 32'h1);
         chk($sformatf("hold%0d_ret", i), retire_cnt, exp_ret);
      end
      hold = 0; in_valid = 0;
      tick();
      exp_ret++;
      chk("rel_wbv", {31'd0, wb_valid}, 1);
      chk("rel_ret", retire_cnt, exp_ret);
      rd_rf(5'd13, 32'h2, "rel_rf13");
      tick();
      chk("rel_wbv2", {31'd0, wb_valid}, 0);
      chk("rel_ret2", retire_cnt, exp_ret);

      // same-edge loader write vs writeback
      set_op(5'd6, 5'd7, 5'd3, 4'h0);
      tick();
      in_valid = 0;
      ext_we = 1; ext_waddr = 5'd3; ext_wdata = 32'hDEADBEEF;
      tick();
      ext_we = 0;
      exp_ret++;
      rd_rf(5'd3, 32'h80000000, "conf_rf3");
      set_op(5'd6, 5'd6, 5'd14, 4'h0);
      tick();
      in_valid = 0;
      ext_we = 1; ext_waddr = 5'd4; ext_wdata = 32'hDEADBEEF;
      tick();
      ext_we = 0;
      exp_ret++;
      rd_rf(5'd14, 32'h2, "conf_rf14");
      rd_rf(5'd4, 32'hDEADBEEF, "conf_rf4");

      // loader data forwarded into same-edge issue
      ext_we = 1; ext_waddr = 5'd15; ext_wdata = 32'h55;
      set_op(5'd15, 5'd6, 5'd16, 4'h0);
      tick();
      ext_we = 0; in_valid = 0;
      chk("extfwd_a", alu_a, 32'h55);
      tick();
      exp_ret++;
      rd_rf(5'd16, 32'h56, "extfwd_rf16");
      rd_rf(5'd15, 32'h55, "extfwd_rf15");
      chk("final_ret", retire_cnt, exp_ret);

      // reset with an op in EX
      set_op(5'd1, 5'd6, 5'd17, 4'h6);
      tick();
      in_valid = 0;
      chk("mid_a", alu_a, 32'h10);
      rst_n = 0;
      #1;
      chk("mid_rst_a", alu_a, 0);
      chk("mid_rst_b", alu_b, 0);
      chk("mid_rst_ret", retire_cnt, 0);
      chk("mid_rst_flags", {28'd0, flags_q}, 0);
      rd_rf(5'd1, 32'h0, "mid_rst_rf1");
      tick();
      rst_n = 1;
      tick();
      chk("mid_no_wb", {31'd0, wb_valid}, 0);
      chk("mid_ret", retire_cnt, 0);
      rd_rf(5'd17, 32'h0, "mid_rf17");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
